// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win; LSU results queue in a FIFO.
// Optional WB_BYPASS_EN: LSU result skips an empty FIFO when ALU is idle.
module wb_arbiter #(
  parameter int XLen        = 32,
  parameter int NReg        = 32,
  parameter int NRegWidth   = $clog2(NReg),
  parameter int FifoDepth   = 4,
  parameter int StarveLimit = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           alu_valid_i,
  input  logic [NRegWidth-1:0]           alu_rd_i,
  input  logic [XLen-1:0]                alu_wd_i,
  input  logic                           lsu_valid_i,
  output logic                           lsu_ready_o,
  input  logic [NRegWidth-1:0]           lsu_rd_i,
  input  logic [XLen-1:0]                lsu_wd_i,
  output logic                           we3_o,
  output logic [NRegWidth-1:0]           a3_o,
  output logic [XLen-1:0]                wd3_o,
  output logic                           stall_o,
  output logic [$clog2(FifoDepth+1)-1:0] fifo_count_o
);

  localparam int CntW = $clog2(FifoDepth + 1);
  localparam int PtrW = $clog2(FifoDepth);
  localparam int StW  = $clog2(StarveLimit + 1);

  logic [NRegWidth-1:0] r_rd_q [FifoDepth];
  logic [XLen-1:0]      r_wd_q [FifoDepth];
  logic [PtrW-1:0]      r_wptr;
  logic [PtrW-1:0]      r_rptr;
  logic [CntW-1:0]      r_count;
  logic [StW-1:0]       r_starve;
  logic                 r_stall;
  logic                 r_we3;
  logic [NRegWidth-1:0] r_a3;
  logic [XLen-1:0]      r_wd3;

  logic w_empty;
  logic w_ready;
  logic w_push;
  logic w_bypass;
  logic w_push_fifo;
  logic w_pop;

  assign w_empty = (r_count == '0);
  assign w_ready = (r_count < CntW'(FifoDepth));
  assign w_push  = lsu_valid_i & w_ready;
  assign w_pop   = ~alu_valid_i & ~w_empty;

`ifdef WB_BYPASS_EN
  assign w_bypass = w_push & w_empty & ~alu_valid_i;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push_fifo = w_push & ~w_bypass;

  always_ff @(posedge clk_i) begin
    if (w_push_fifo) begin
      r_rd_q[r_wptr] <= lsu_rd_i;
      r_wd_q[r_wptr] <= lsu_wd_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_fifo) r_wptr <= r_wptr + 1'b1;
      if (w_pop)       r_rptr <= r_rptr + 1'b1;
      unique case ({w_push_fifo, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Starvation: FIFO holds data but ALU keeps the slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      if (w_empty || w_pop)
        r_starve <= '0;
      else if (r_starve != StW'(StarveLimit))
        r_starve <= r_starve + StW'(1);

      if (w_pop)
        r_stall <= 1'b0;
      else if (r_starve == StW'(StarveLimit))
        r_stall <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we3 <= 1'b0;
      r_a3  <= '0;
      r_wd3 <= '0;
    end else if (alu_valid_i) begin
      r_we3 <= (alu_rd_i != '0);
      r_a3  <= alu_rd_i;
      r_wd3 <= alu_wd_i;
    end else if (!w_empty) begin
      r_we3 <= (r_rd_q[r_rptr] != '0);
      r_a3  <= r_rd_q[r_rptr];
      r_wd3 <= r_wd_q[r_rptr];
    end else if (w_bypass) begin
      r_we3 <= (lsu_rd_i != '0);
      r_a3  <= lsu_rd_i;
      r_wd3 <= lsu_wd_i;
    end else begin
      r_we3 <= 1'b0;
    end
  end

  assign lsu_ready_o  = w_ready;
  assign we3_o        = r_we3;
  assign a3_o         = r_a3;
  assign wd3_o        = r_wd3;
  assign stall_o      = r_stall;
  assign fifo_count_o = r_count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with default parameters.
// Expectations are hand-computed for FifoDepth=4, StarveLimit=8.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_v;
  logic [4:0]  alu_rd;
  logic [31:0] alu_wd;
  logic        lsu_v;
  logic        lsu_rdy;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_wd;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic        stall;
  logic [2:0]  cnt;

  int n_chk;
  int n_err;

  wb_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .alu_valid_i (alu_v),
    .alu_rd_i    (alu_rd),
    .alu_wd_i    (alu_wd),
    .lsu_valid_i (lsu_v),
    .lsu_ready_o (lsu_rdy),
    .lsu_rd_i    (lsu_rd),
    .lsu_wd_i    (lsu_wd),
    .we3_o       (we3),
    .a3_o        (a3),
    .wd3_o       (wd3),
    .stall_o     (stall),
    .fifo_count_o(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_err  = 0;
    rst    = 1'b1;
    alu_v  = 1'b0;
    alu_rd = '0;
    alu_wd = '0;
    lsu_v  = 1'b0;
    lsu_rd = '0;
    lsu_wd = '0;
    tick();
    tick();
    rst = 1'b0;

    // Fill 3 entries behind a busy ALU, then reset mid-operation
    alu_v  = 1'b1;
    alu_rd = 5'd1;
    alu_wd = 32'h1;
    lsu_v  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lsu_rd = 5'(10 + i);
      lsu_wd = 32'hA0 + 32'(i);
      tick();
    end
    chk("fill3_cnt", 32'(cnt), 32'd3);
    rst = 1'b1;
    #1;
    chk("async_rst_cnt", 32'(cnt), 32'd0);
    chk("async_rst_we3", 32'(we3), 32'd0);
    alu_v = 1'b0;
    lsu_v = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_we3", 32'(we3), 32'd0);
    chk("rst_a3", 32'(a3), 32'd0);
    chk("rst_wd3", wd3, 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_rdy", 32'(lsu_rdy), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);

    // ALU only, then x0 destination
    alu_v  = 1'b1;
    alu_rd = 5'd5;
    alu_wd = 32'hDEADBEEF;
    tick();
    chk("alu_we3", 32'(we3), 32'd1);
    chk("alu_a3", 32'(a3), 32'd5);
    chk("alu_wd3", wd3, 32'hDEADBEEF);
    alu_rd = 5'd0;
    alu_wd = 32'h55;
    tick();
    chk("alu_x0_we3", 32'(we3), 32'd0);
    chk("alu_x0_a3", 32'(a3), 32'd0);
    chk("alu_x0_wd3", wd3, 32'h55);
    alu_v = 1'b0;
    tick();
    chk("idle_we3", 32'(we3), 32'd0);

    // LSU only, ALU idle
    lsu_v  = 1'b1;
    lsu_rd = 5'd7;
    lsu_wd = 32'h12345678;
    chk("lsu_rdy", 32'(lsu_rdy), 32'd1);
    tick();
    lsu_v = 1'b0;
`ifdef WB_BYPASS_EN
    chk("lsu1_we3", 32'(we3), 32'd1);
    chk("lsu1_a3", 32'(a3), 32'd7);
    chk("lsu1_wd3", wd3, 32'h12345678);
    chk("lsu1_cnt", 32'(cnt), 32'd0);
    tick();
    chk("lsu2_we3", 32'(we3), 32'd0);
    chk("lsu2_cnt", 32'(cnt), 32'd0);
`else
    chk("lsu1_we3", 32'(we3), 32'd0);
    chk("lsu1_cnt", 32'(cnt), 32'd1);
    tick();
    chk("lsu2_we3", 32'(we3), 32'd1);
    chk("lsu2_a3", 32'(a3), 32'd7);
    chk("lsu2_wd3", wd3, 32'h12345678);
    chk("lsu2_cnt", 32'(cnt), 32'd0);
`endif

    // Busy ALU: fill FIFO, hold 5th offer, starve into stall
    alu_v  = 1'b1;
    alu_rd = 5'd3;
    lsu_v  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      alu_wd = 32'(i);
      lsu_rd = 5'(20 + ((i < 4) ? i : 4));
      lsu_wd = 32'h100 + 32'((i < 4) ? i : 4);
      tick();
      chk("busy_a3", 32'(a3), 32'd3);
      chk("busy_wd3", wd3, 32'(i));
      chk("busy_cnt", 32'(cnt), 32'((i < 3) ? i + 1 : 4));
      chk("busy_stall", 32'(stall), 32'(i == 9));
    end
    chk("full_rdy", 32'(lsu_rdy), 32'd0);

    // Drain: in-order pops, held entry enters once ready
    alu_v = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("drain_we3", 32'(we3), 32'd1);
      chk("drain_a3", 32'(a3), 32'(20 + j));
      chk("drain_wd3", wd3, 32'h100 + 32'(j));
      chk("drain_cnt", 32'(cnt), 32'((j < 2) ? 3 : 4 - j));
      chk("drain_stall", 32'(stall), 32'd0);
      if (j == 1) lsu_v = 1'b0;
    end
    tick();
    chk("drained_we3", 32'(we3), 32'd0);

    // Steady push+pop at count 2 across pointer wrap
    alu_v  = 1'b1;
    alu_rd = 5'd4;
    lsu_v  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      lsu_rd = 5'(8 + k);
      lsu_wd = 32'h2000 + 32'(k);
      tick();
    end
    chk("pp_cnt_pre", 32'(cnt), 32'd2);
    alu_v = 1'b0;
    for (int k = 2; k < 12; k++) begin
      lsu_v  = (k <= 9);
      lsu_rd = 5'(8 + k);
      lsu_wd = 32'h2000 + 32'(k);
      tick();
      chk("pp_we3", 32'(we3), 32'd1);
      chk("pp_a3", 32'(a3), 32'(6 + k));
      chk("pp_wd3", wd3, 32'h2000 + 32'(k - 2));
      chk("pp_cnt", 32'(cnt), 32'((k <= 9) ? 2 : 11 - k));
    end
    lsu_v = 1'b0;
    tick();
    chk("end_we3", 32'(we3), 32'd0);
    chk("end_cnt", 32'(cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
